// File: rtl/cnn_acc_requant_23s_14s.sv
// Accumulates cfg_k signed products plus a bias per output pixel, then requantises
// the sum to the 14-bit activation format (rounding shift, saturation, optional ReLU).
module cnn_acc_requant_23s_14s #(
  parameter int PROD_WIDTH  = 23,
  parameter int ACC_WIDTH   = 32,
  parameter int OUT_WIDTH   = 14,
  parameter int K_WIDTH     = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [K_WIDTH-1:0]          cfg_k,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic                        cfg_relu,
  input  logic signed [ACC_WIDTH-1:0] bias,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PROD_WIDTH-1:0]       in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic                        out_sat
);

  localparam logic [1:0] ST_ACC = 2'd0;
  localparam logic [1:0] ST_RQ  = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

  // One extra bit so the rounding add can never overflow the accumulator range.
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] OUT_MAX = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] OUT_MIN = -OUT_MAX - RW'(1);

  logic [1:0]                  state;
  logic [K_WIDTH-1:0]          cnt;
  logic [K_WIDTH-1:0]          k_eff;
  logic [SHIFT_WIDTH-1:0]      shift_q;
  logic                        relu_q;
  logic signed [ACC_WIDTH-1:0] acc;

  logic                        beat;
  logic                        first;
  logic [K_WIDTH-1:0]          k_new;
  logic [K_WIDTH-1:0]          k_cur;
  logic [K_WIDTH-1:0]          cnt_inc;
  logic                        last_beat;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;

  logic [RW-1:0]               round_add;
  logic signed [RW-1:0]        acc_ext;
  logic signed [RW-1:0]        rounded;
  logic signed [RW-1:0]        clipped;
  logic [OUT_WIDTH-1:0]        res_data;
  logic                        res_sat;

  assign in_ready = (state == ST_ACC) && !ap_rst;
  assign beat     = in_valid && in_ready;
  assign first    = (cnt == '0);

  // The group length is taken from cfg_k on the first beat and frozen thereafter.
  assign k_new     = (cfg_k == '0) ? K_WIDTH'(1) : cfg_k;
  assign k_cur     = first ? k_new : k_eff;
  assign cnt_inc   = cnt + 1'b1;
  assign last_beat = (cnt_inc == k_cur);

  assign prod_ext = {{(ACC_WIDTH - PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
  assign acc_next = (first ? bias : acc) + prod_ext;

  // NOTE: every variable assigned in always_comb gets a default first so no path infers a latch.
  always_comb begin
    round_add = '0;
    acc_ext   = {acc[ACC_WIDTH-1], acc};
    rounded   = acc_ext;
    clipped   = acc_ext;
    res_sat   = 1'b0;
    res_data  = '0;

    // 2^(shift-1) as (1 << shift) >> 1, which is zero when shift is zero.
    round_add = (RW'(1) << shift_q) >> 1;
    rounded   = (acc_ext + $signed(round_add)) >>> shift_q;

    if (rounded > OUT_MAX) begin
      clipped = OUT_MAX;
      res_sat = 1'b1;
    end else if (rounded < OUT_MIN) begin
      clipped = OUT_MIN;
      res_sat = 1'b1;
    end else begin
      clipped = rounded;
    end

    res_data = clipped[OUT_WIDTH-1:0];
    if (relu_q && res_data[OUT_WIDTH-1]) begin
      res_data = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc       <= '0;
      k_eff     <= K_WIDTH'(1);
      shift_q   <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (beat) begin
            acc <= acc_next;
            if (first) begin
              k_eff   <= k_new;
              shift_q <= cfg_shift;
              relu_q  <= cfg_relu;
            end
            if (last_beat) begin
              cnt   <= '0;
              state <= ST_RQ;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end

        ST_RQ: begin
          out_data  <= res_data;
          out_sat   <= res_sat;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end

        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_ACC;
          end
        end

        default: begin
          state     <= ST_ACC;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_acc_requant_23s_14s.sv
// Directed and randomised checks of the accumulate/requantise block against an
// arithmetic reference model of the group sum and requantisation rules.
module tb_cnn_acc_requant_23s_14s;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic [7:0]         cfg_k;
  logic [4:0]         cfg_shift;
  logic               cfg_relu;
  logic signed [31:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic [22:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [13:0] out_data;
  logic               out_sat;

  int passed = 0;
  int total  = 0;

  cnn_acc_requant_23s_14s dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .cfg_k     (cfg_k),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Reference: exact integer sum, floor((s + 2^(sh-1)) / 2^sh), clip, then ReLU.
  function automatic void model(input longint s, input int sh, input bit rl,
                                output longint q, output bit sat);
    longint r;
    r   = (sh == 0) ? s : ((s + (longint'(1) << (sh - 1))) >>> sh);
    sat = 1'b0;
    if (r > 8191) begin
      r   = 8191;
      sat = 1'b1;
    end else if (r < -8192) begin
      r   = -8192;
      sat = 1'b1;
    end
    if (rl && r < 0) r = 0;
    q = r;
  endfunction

  task automatic beat(input int d);
    int n;
    n = 0;
    @(negedge ap_clk);
    while (!in_ready && n < 20) begin
      @(negedge ap_clk);
      n++;
    end
    check("beat_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d[22:0];
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_group(input string tag, input int k, input longint b, input int sh,
                           input bit rl, input int prods[$], input int hold);
    longint sum;
    longint exp_q;
    bit     exp_sat;
    logic signed [13:0] held;
    cfg_k     = k[7:0];
    cfg_shift = sh[4:0];
    cfg_relu  = rl;
    bias      = b[31:0];
    sum       = b;
    foreach (prods[i]) begin
      beat(prods[i]);
      sum += prods[i];
      if (i == 0) begin
        // Mid-group config changes must not affect the running group.
        cfg_k     = 8'($urandom);
        cfg_shift = 5'($urandom);
        cfg_relu  = 1'($urandom);
        bias      = 32'($urandom);
      end
    end
    model(sum, sh, rl, exp_q, exp_sat);

    @(negedge ap_clk);
    check({tag, "_valid_early"}, out_valid, 0);
    check({tag, "_rq_in_ready"}, in_ready, 0);
    @(negedge ap_clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_q);
    check({tag, "_sat"}, out_sat, longint'(exp_sat));

    held = out_data;
    for (int c = 0; c < hold; c++) begin
      @(negedge ap_clk);
      check({tag, "_hold_data"}, out_data, held);
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end

    out_ready = 1'b1;
    @(posedge ap_clk);
    #1 out_ready = 1'b0;
    @(negedge ap_clk);
    check({tag, "_valid_clear"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int     nprod;
    int     prods[$];
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    cfg_k     = 8'd1;
    cfg_shift = '0;
    cfg_relu  = 1'b0;
    bias      = '0;

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready_after", in_ready, 1);

    run_group("k3_sum", 3, 0, 0, 0, '{100, 200, -50}, 0);
    run_group("k3_hold", 3, 0, 0, 0, '{100, 200, -50}, 5);
    run_group("rnd_p5", 1, 0, 1, 0, '{5}, 0);
    run_group("rnd_m5", 1, 0, 1, 0, '{-5}, 0);
    run_group("rnd_m6", 1, 0, 1, 0, '{-6}, 0);
    run_group("sat_pos", 2, 0, 0, 0, '{4000000, 4000000}, 0);
    run_group("sat_neg", 2, 0, 0, 0, '{-4000000, -4000000}, 0);
    run_group("relu_neg", 1, 0, 0, 1, '{-300}, 0);
    run_group("relu_bias", 1, 500, 0, 1, '{-300}, 0);
    run_group("k0_as_1", 0, 7, 0, 0, '{-20}, 0);
    run_group("relu_sat", 1, 0, 0, 1, '{-4000000}, 0);

    // Reset in the middle of a group discards the partial sum.
    cfg_k     = 8'd4;
    cfg_shift = '0;
    cfg_relu  = 1'b0;
    bias      = '0;
    beat(1000);
    beat(2000);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    run_group("post_rst", 4, 0, 0, 0, '{1, 2, 3, 4}, 0);

    for (int g = 0; g < 25; g++) begin
      int k;
      k     = int'($urandom_range(0, 6));
      nprod = (k == 0) ? 1 : k;
      prods = {};
      for (int i = 0; i < nprod; i++)
        prods.push_back(int'($urandom_range(0, 8388607)) - 4194304);
      run_group($sformatf("rand%0d", g), k,
                longint'(int'($urandom_range(0, 2097151)) - 1048576),
                int'($urandom_range(0, 20)), 1'($urandom), prods,
                int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
